// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DefDw = 32;
  localparam int unsigned DefVw = 16;

  // Quotient reported for a zero divisor.
  localparam logic [DefDw-1:0] DivZeroQuot = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int unsigned VW = 16
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   rem_o,
  output logic          q_o
);

  // One extra bit so the sign of the trial difference is always visible.
  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;

  // Trial subtraction; keep the difference when it is non-negative.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_o     = ~diff[VW+1];
    rem_o   = q_o ? diff[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential DW-by-VW unsigned restoring divider, one quotient bit per cycle, MSB first.
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned VW = DefVw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int unsigned CW = $clog2(DW);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [DW-1:0] shreg_q, shreg_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   prem_q, prem_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_rem;
  logic          step_q;

  div_step #(
    .VW (VW)
  ) u_step (
    .rem_i     (prem_q),
    .bit_i     (shreg_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Next-state logic: accept in IDLE, iterate in RUN, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            shreg_d = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CW'(DW - 1);
          end else begin
            state_d = DONE;
            quot_d  = {DW{DivZeroQuot[0]}};
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        shreg_d = {shreg_q[DW-2:0], step_q};
        prem_d  = step_rem;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = {shreg_q[DW-2:0], step_q};
          rem_d   = step_rem[VW-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus a randomized round-trip regression.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  seq_divider #(
    .DW (32),
    .VW (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge where done is seen.
  // lat counts clock edges after the accepting edge; busy_n counts cycles busy was high.
  // If poke_at >= 0, a stray start (100 / 7) is pulsed for one cycle at that point.
  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, input int poke_at,
                        output int lat, output int busy_n);
    start = 1'b1;
    dividend = dvd;
    divisor = dvs;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = 16'($urandom);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (lat == poke_at) begin
        start = 1'b1;
        dividend = 32'd100;
        divisor = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("done_within_bound", 64'(done), 64'd1);
  endtask

  // Confirms done drops after one cycle; leaves the DUT idle at a negedge.
  task automatic close_op(input string tag);
    @(negedge clk);
    chk(tag, 64'(done), 64'd0);
  endtask

  int          lat;
  int          busy_n;
  int          done_n;
  logic [31:0] ra;
  logic [15:0] rb;
  logic [15:0] rr;
  longint unsigned amax;
  longint unsigned wide;
  logic [31:0] rdvd;

  initial begin
    rst = 1'b1;
    start = 1'b1;
    dividend = 32'd50;
    divisor = 16'd5;
    // start held during reset must be lost
    repeat (3) @(negedge clk);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_lost_in_reset", 64'(busy), 64'd0);

    // 7006652 / 5678 with latency and busy-length checks
    run_op(32'd7006652, 16'd5678, -1, lat, busy_n);
    chk("basic_latency", 64'(lat), 64'd32);
    chk("basic_busy_cycles", 64'(busy_n), 64'd32);
    chk("basic_quotient", 64'(quotient), 64'd1234);
    chk("basic_remainder", 64'(remainder), 64'd0);
    chk("basic_dbz", 64'(div_by_zero), 64'd0);
    close_op("basic_done_single");
    chk("basic_quotient_held", 64'(quotient), 64'd1234);

    run_op(32'hFFFE_0001, 16'hFFFF, -1, lat, busy_n);
    chk("maxdiv_quotient", 64'(quotient), 64'h0000_FFFF);
    chk("maxdiv_remainder", 64'(remainder), 64'd0);
    close_op("maxdiv_done_single");

    run_op(32'd110939, 16'd111, -1, lat, busy_n);
    chk("rem50_quotient", 64'(quotient), 64'd999);
    chk("rem50_remainder", 64'(remainder), 64'd50);
    close_op("rem50_done_single");

    run_op(32'hFFFF_FFFF, 16'd1, -1, lat, busy_n);
    chk("div1_quotient", 64'(quotient), 64'hFFFF_FFFF);
    chk("div1_remainder", 64'(remainder), 64'd0);
    close_op("div1_done_single");

    // Zero divisor: done after the accepting edge itself, busy never asserted
    run_op(32'd1234, 16'd0, -1, lat, busy_n);
    chk("dbz_latency", 64'(lat), 64'd0);
    chk("dbz_busy_cycles", 64'(busy_n), 64'd0);
    chk("dbz_flag", 64'(div_by_zero), 64'd1);
    chk("dbz_quotient", 64'(quotient), 64'hFFFF_FFFF);
    chk("dbz_remainder", 64'(remainder), 64'd1234);
    close_op("dbz_done_single");
    chk("dbz_flag_held", 64'(div_by_zero), 64'd1);

    // Start pulsed mid-run must be ignored, with a single done
    run_op(32'd5555, 16'd3, 10, lat, busy_n);
    chk("ignore_quotient", 64'(quotient), 64'd1851);
    chk("ignore_remainder", 64'(remainder), 64'd2);
    chk("ignore_dbz_cleared", 64'(div_by_zero), 64'd0);
    close_op("ignore_done_single");
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    chk("ignore_no_second_run", 64'(done_n), 64'd0);

    // Reset mid-run aborts with no done
    start = 1'b1;
    dividend = 32'd5555;
    divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort_no_done", 64'(done_n), 64'd0);
    run_op(32'd200, 16'd10, -1, lat, busy_n);
    chk("after_abort_quotient", 64'(quotient), 64'd20);
    chk("after_abort_remainder", 64'(remainder), 64'd0);
    close_op("after_abort_done_single");

    // Random round trip: dividend = a*b + r with r < b, expect a r r.
    // Each new start is raised in the cycle right after done.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3, 0) == 0) rb = 16'($urandom_range(15, 1));
      else rb = 16'($urandom_range(65535, 1));
      amax = (64'hFFFF_FFFF - (64'(rb) - 1)) / 64'(rb);
      wide = {$urandom, $urandom};
      ra = 32'(wide % (amax + 1));
      rr = 16'($urandom_range(32'(rb) - 1, 0));
      rdvd = 32'(64'(ra) * 64'(rb) + 64'(rr));
      run_op(rdvd, rb, -1, lat, busy_n);
      chk("rand_quotient", 64'(quotient), 64'(ra));
      chk("rand_remainder", 64'(remainder), 64'(rr));
      if (i % 100 == 0) chk("rand_latency", 64'(lat), 64'd32);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
